// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scan controller: protocol byte values,
// the handshake and parser state encodings, and the key-event record that
// flows through the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_E0      = 8'hE0;
  localparam logic [7:0] PS2_F0      = 8'hF0;
  localparam logic [7:0] PS2_BAT     = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_BATFAIL = 8'hFC;

  typedef enum logic [1:0] {
    P_IDLE,
    P_E0,
    P_F0,
    P_E0F0
  } parseState_e;

  typedef enum logic [1:0] {
    H_WAIT,
    H_CLR,
    H_DROP
  } hsState_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2Event_t;

  // Command responses and keyboard error/overrun codes that carry no key
  // information when they arrive outside a prefix sequence.
  function automatic logic isDropCode(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_BATFAIL) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
// First-word fall-through FIFO for key events. The head entry is visible on
// rdData whenever empty is low. A push while full is only accepted when a
// pop happens in the same cycle.
//
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   wrEn        push request
//   wrData      entry to push
//   rdEn        pop request (ignored while empty)
//   rdData      current head entry
//   full        DEPTH entries stored
//   empty       no entries stored
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the address
  // bits match.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = rdEn && !empty;
  assign doPush = wrEn && (!full || doPop);
  assign rdData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset; stale contents are never presented because the
  // consumer only looks at the head while empty is low.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl
// System-clock side of the PS/2 keyboard path. Synchronizes the receiver's
// byte-ready flag, captures each byte, pulses the receiver's ready-clear,
// folds E0/F0 prefixes into make/break key events and queues them in a
// small FIFO with a valid/ready interface.
//
// Optional build macro:
//   PS2_TIMEOUT_EN  abandon a prefix sequence after TIMEOUT_CYC clk cycles
//                   without a follow-up byte (pulses proto_err).
//
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   rx_dready    receiver byte-ready flag (asynchronous to clk)
//   rx_data      receiver byte, stable while rx_dready is high
//   rx_clr       ready-clear pulse back to the receiver
//   ev_valid     event available at the FIFO head
//   ev_ready     consumer accepts the head event
//   ev_code      scancode without prefixes
//   ev_ext       event carried an E0 prefix
//   ev_break     key release (F0 seen)
//   kbd_ok       sticky, keyboard reported BAT pass (0xAA)
//   ovf          sticky, an event was dropped on a full FIFO
//   proto_err    one-cycle pulse on an illegal prefix sequence
//   clr_status   clears kbd_ok and ovf
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 24000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_dready,
  input  logic [7:0] rx_data,
  output logic       rx_clr,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       kbd_ok,
  output logic       ovf,
  output logic       proto_err,
  input  logic       clr_status
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  logic        dreadyS1;
  logic        dreadyS2;
  logic        dreadyS3;
  logic        dreadyRise;

  hsState_e    hsState;
  hsState_e    hsNext;
  logic [CW-1:0] clrCnt;
  logic        capture;
  logic [7:0]  byteQ;
  logic        byteValid;

  parseState_e pState;
  parseState_e pNext;
  logic        emit;
  ps2Event_t   emitEv;
  logic        protoErrSet;
  logic        kbdSet;
  logic        timeoutHit;

  ps2Event_t   headEv;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        pop;
  logic        ovfSet;

  // Synchronizer plus one edge-detect stage. These flops are deliberately
  // left out of reset so they keep tracking rx_dready through a reset;
  // a flag that is already high when reset releases then shows no edge and
  // that byte is skipped instead of being captured late.
  always_ff @(posedge clk) begin
    dreadyS1 <= rx_dready;
    dreadyS2 <= dreadyS1;
    dreadyS3 <= dreadyS2;
  end

  assign dreadyRise = dreadyS2 && !dreadyS3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsState   <= H_WAIT;
      clrCnt    <= '0;
      byteQ     <= '0;
      byteValid <= 1'b0;
    end else begin
      hsState   <= hsNext;
      byteValid <= capture;
      if (capture) byteQ <= rx_data;
      if (hsState == H_CLR) clrCnt <= clrCnt + 1'b1;
      else                  clrCnt <= '0;
    end
  end

  // The clear pulse is held for CLR_CYCLES, then we wait for the synced
  // flag to actually drop so one byte can never be captured twice.
  always_comb begin
    hsNext  = hsState;
    capture = 1'b0;
    rx_clr  = 1'b0;
    case (hsState)
      H_WAIT: begin
        if (dreadyRise) begin
          capture = 1'b1;
          hsNext  = H_CLR;
        end
      end
      H_CLR: begin
        rx_clr = 1'b1;
        if (clrCnt == CW'(CLR_CYCLES - 1)) hsNext = H_DROP;
      end
      H_DROP: begin
        if (!dreadyS2) hsNext = H_WAIT;
      end
      default: hsNext = H_WAIT;
    endcase
  end

`ifdef PS2_TIMEOUT_EN
  logic [15:0] tmoCnt;

  // Counts clk cycles spent waiting inside a prefix sequence; any new byte
  // restarts the wait.
  always_ff @(posedge clk) begin
    if (!rst_n || pState == P_IDLE || byteValid) tmoCnt <= '0;
    else                                        tmoCnt <= tmoCnt + 1'b1;
  end

  assign timeoutHit = (pState != P_IDLE) && !byteValid &&
                      (tmoCnt == 16'(TIMEOUT_CYC - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) pState <= P_IDLE;
    else        pState <= pNext;
  end

  // One transition per captured byte. A repeated E0 keeps the parser in
  // P_E0 so the byte after it is still treated as extended.
  always_comb begin
    pNext       = pState;
    emit        = 1'b0;
    emitEv      = '{code: byteQ, ext: 1'b0, brk: 1'b0};
    protoErrSet = 1'b0;
    kbdSet      = 1'b0;
    if (byteValid) begin
      case (pState)
        P_IDLE: begin
          if (byteQ == PS2_E0)          pNext  = P_E0;
          else if (byteQ == PS2_F0)     pNext  = P_F0;
          else if (byteQ == PS2_BAT)    kbdSet = 1'b1;
          else if (!isDropCode(byteQ))  emit   = 1'b1;
        end
        P_E0: begin
          if (byteQ == PS2_F0) begin
            pNext = P_E0F0;
          end else if (byteQ == PS2_E0) begin
            protoErrSet = 1'b1;
          end else begin
            emit       = 1'b1;
            emitEv.ext = 1'b1;
            pNext      = P_IDLE;
          end
        end
        P_F0: begin
          pNext = P_IDLE;
          if (byteQ == PS2_E0 || byteQ == PS2_F0) begin
            protoErrSet = 1'b1;
          end else begin
            emit       = 1'b1;
            emitEv.brk = 1'b1;
          end
        end
        P_E0F0: begin
          pNext = P_IDLE;
          if (byteQ == PS2_E0 || byteQ == PS2_F0) begin
            protoErrSet = 1'b1;
          end else begin
            emit       = 1'b1;
            emitEv.ext = 1'b1;
            emitEv.brk = 1'b1;
          end
        end
        default: pNext = P_IDLE;
      endcase
    end else if (timeoutHit) begin
      pNext       = P_IDLE;
      protoErrSet = 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (emit),
    .wrData (emitEv),
    .rdEn   (pop),
    .rdData (headEv),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign ev_valid = !fifoEmpty;
  assign pop      = ev_valid && ev_ready;
  // A same-cycle pop frees the slot, so only an unrelieved full drops.
  assign ovfSet   = emit && fifoFull && !pop;

  // Head fields are zeroed while empty so uninitialised storage never leaks.
  assign ev_code  = ev_valid ? headEv.code : 8'h00;
  assign ev_ext   = ev_valid && headEv.ext;
  assign ev_break = ev_valid && headEv.brk;

  // Sticky status: a set in the same cycle as clr_status wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbd_ok    <= 1'b0;
      ovf       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= protoErrSet;
      if (kbdSet)          kbd_ok <= 1'b1;
      else if (clr_status) kbd_ok <= 1'b0;
      if (ovfSet)          ovf <= 1'b1;
      else if (clr_status) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl
// Directed bench for ps2_scan_ctrl. Stimulus pushes the expected key events
// into a scoreboard queue; an independent monitor pops and compares each
// event the DUT hands over on the valid/ready interface.
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dready;
  logic [7:0] rx_data;
  logic       rx_clr;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       kbd_ok;
  logic       ovf;
  logic       proto_err;
  logic       clr_status;

  int testsRun    = 0;
  int testsFailed = 0;
  int protoCnt    = 0;
  int clrHighCnt  = 0;
  int lastLat;
  int lastWidth;
  int snap;

  logic [9:0] expQ[$];

  ps2_scan_ctrl #(
    .FIFO_DEPTH  (4),
    .CLR_CYCLES  (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dready  (rx_dready),
    .rx_data    (rx_data),
    .rx_clr     (rx_clr),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .kbd_ok     (kbd_ok),
    .ovf        (ovf),
    .proto_err  (proto_err),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every handed-over event must match the oldest
  // expected one.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected event: got %0h expected none",
                 {ev_code, ev_ext, ev_break});
      end else begin
        checkOutput("event", {22'd0, ev_code, ev_ext, ev_break},
                    {22'd0, expQ.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (proto_err) protoCnt++;
    if (rx_clr)    clrHighCnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Plays the receiver: raise the flag, drop it once the clear pulse ends.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    @(posedge clk);
    #1;
    rx_data   = b;
    rx_dready = 1'b1;
    n         = 0;
    lastLat   = 0;
    lastWidth = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (rx_clr) begin
        if (lastWidth == 0) lastLat = n;
        lastWidth++;
      end else if (lastWidth > 0) begin
        break;
      end
    end
    if (lastWidth == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL rx_clr wait: got no pulse expected pulse for byte %0h", b);
    end
    tick(1);
    rx_dready = 1'b0;
    tick(6);
  endtask

  task automatic pushExp(input logic [7:0] code, input logic ext, input logic brk);
    expQ.push_back({code, ext, brk});
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      tick(1);
      n++;
    end
    tick(2);
    checkOutput("drain", expQ.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_dready  = 1'b0;
    rx_data    = 8'h00;
    ev_ready   = 1'b1;
    clr_status = 1'b0;
    tick(4);
    checkOutput("reset values",
                {17'd0, rx_clr, ev_valid, ev_code, ev_ext, ev_break, kbd_ok, ovf, proto_err},
                32'd0);
    rst_n = 1'b1;
    tick(4);

    // Plain make code, with capture latency and clear width
    pushExp(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    checkOutput("rx_clr latency", lastLat, 4);
    checkOutput("rx_clr width", lastWidth, 2);
    waitDrain();

    // Extended break sequence
    snap = protoCnt;
    pushExp(8'h75, 1'b1, 1'b1);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    waitDrain();
    checkOutput("no err on E0 F0", protoCnt - snap, 0);

    // F0 then E0 is illegal; parser recovers to idle
    snap = protoCnt;
    applyStimulus(8'hF0);
    applyStimulus(8'hE0);
    checkOutput("proto_err F0 E0", protoCnt - snap, 1);
    pushExp(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    waitDrain();

    // Double E0 flags an error but stays extended
    snap = protoCnt;
    applyStimulus(8'hE0);
    applyStimulus(8'hE0);
    checkOutput("proto_err E0 E0", protoCnt - snap, 1);
    pushExp(8'h74, 1'b1, 1'b0);
    applyStimulus(8'h74);
    waitDrain();

    // Plain break
    pushExp(8'h1C, 1'b0, 1'b1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    waitDrain();

    // BAT pass and ACK produce no events
    applyStimulus(8'hAA);
    applyStimulus(8'hFA);
    checkOutput("kbd_ok", kbd_ok, 1);
    checkOutput("no event for AA FA", ev_valid, 0);

    // Long idle inside a prefix
    snap = protoCnt;
    applyStimulus(8'hE0);
    tick(150);
`ifdef PS2_TIMEOUT_EN
    checkOutput("timeout proto_err", protoCnt - snap, 1);
    pushExp(8'h1C, 1'b0, 1'b0);
`else
    checkOutput("no timeout", protoCnt - snap, 0);
    pushExp(8'h1C, 1'b1, 1'b0);
`endif
    applyStimulus(8'h1C);
    waitDrain();

    // Overflow: five make codes into a four-entry FIFO
    ev_ready = 1'b0;
    checkOutput("ovf before", ovf, 0);
    pushExp(8'h1C, 1'b0, 1'b0);
    pushExp(8'h1B, 1'b0, 1'b0);
    pushExp(8'h23, 1'b0, 1'b0);
    pushExp(8'h2B, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    applyStimulus(8'h1B);
    applyStimulus(8'h23);
    applyStimulus(8'h2B);
    checkOutput("ovf at full", ovf, 0);
    applyStimulus(8'h34);
    checkOutput("ovf set", ovf, 1);
    checkOutput("head kept", ev_code, 8'h1C);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    tick(1);
    checkOutput("ovf cleared", ovf, 0);
    checkOutput("kbd_ok cleared", kbd_ok, 0);
    ev_ready = 1'b1;
    waitDrain();

    // Reset while a byte is pending and an event is queued
    applyStimulus(8'hAA);
    ev_ready = 1'b0;
    applyStimulus(8'h2C);
    checkOutput("queued before reset", ev_valid, 1);
    @(posedge clk);
    #1;
    rx_data   = 8'h55;
    rx_dready = 1'b1;
    rst_n     = 1'b0;
    tick(4);
    checkOutput("mid-byte reset values",
                {17'd0, rx_clr, ev_valid, ev_code, ev_ext, ev_break, kbd_ok, ovf, proto_err},
                32'd0);
    snap  = clrHighCnt;
    rst_n = 1'b1;
    tick(12);
    checkOutput("no clr after reset", clrHighCnt - snap, 0);
    checkOutput("no capture after reset", ev_valid, 0);
    rx_dready = 1'b0;
    ev_ready  = 1'b1;
    tick(4);
    pushExp(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
